// File: rtl/filter_seq_ctrl.sv
// Filter weight sequencer: loads DEPTH_F*DEPTH_F weights into memory, then emits one packet per row.
// Optional FILTER_REPLAY_EN adds replay_start to resend an already loaded filter without reloading.
module filter_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_F    = 5,
    parameter int ADDR_WIDTH = 5,
    parameter int PACK_WIDTH = 44,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
`ifdef FILTER_REPLAY_EN
    input  logic                  replay_start,
`endif
    input  logic                  wr_in_valid,
    output logic                  wr_in_ready,
    input  logic [WIDTH-1:0]      wr_in_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic [PACK_WIDTH-1:0] pkt_data,
    output logic                  busy,
    output logic                  done
);

    localparam int NWORDS = DEPTH_F * DEPTH_F;
    localparam int RW     = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
    localparam int KW     = $clog2(DEPTH_F + RD_LAT + 1);
    localparam int LW     = DEPTH_F * WIDTH;

    localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(NWORDS - 1);
    localparam logic [RW-1:0]         LAST_R = RW'(DEPTH_F - 1);
    localparam logic [KW-1:0]         LAST_K = KW'(DEPTH_F + RD_LAT - 1);
    localparam logic [KW-1:0]         N_RD   = KW'(DEPTH_F);
    localparam logic [KW-1:0]         LAT    = KW'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] w;
    logic [RW-1:0]         r;
    logic [KW-1:0]         k;
    logic [LW-1:0]         lanes;
    logic                  beat;
    logic [KW-1:0]         lane_idx;
    logic [ADDR_WIDTH-1:0] raddr;
`ifdef FILTER_REPLAY_EN
    logic                  loaded;
`endif

    assign beat     = (state == S_LOAD) && wr_in_valid;
    assign lane_idx = k - LAT;
    assign raddr    = ADDR_WIDTH'(int'(r) * DEPTH_F + int'(k));

    assign wr_in_ready = (state == S_LOAD);
    assign mem_we      = beat;
    assign mem_waddr   = beat ? w : '0;
    assign mem_wdata   = beat ? wr_in_data : '0;

    // k counts the whole READ phase: issue for k < DEPTH_F, capture RD_LAT later
    assign mem_re    = (state == S_READ) && (k < N_RD);
    assign mem_raddr = mem_re ? raddr : '0;

    assign pkt_valid = (state == S_SEND);
    assign pkt_data  = PACK_WIDTH'({4'(r), lanes});
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            w     <= '0;
            r     <= '0;
            k     <= '0;
            lanes <= '0;
`ifdef FILTER_REPLAY_EN
            loaded <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state <= S_LOAD;
                        w     <= '0;
`ifdef FILTER_REPLAY_EN
                        loaded <= 1'b0;
                    end else if (replay_start && loaded) begin
                        state <= S_READ;
                        r     <= '0;
                        k     <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        if (w == LAST_W) begin
                            state <= S_READ;
                            w     <= '0;
                            r     <= '0;
                            k     <= '0;
`ifdef FILTER_REPLAY_EN
                            loaded <= 1'b1;
`endif
                        end else begin
                            w <= w + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (k >= LAT) begin
                        lanes[int'(lane_idx) * WIDTH +: WIDTH] <= mem_rdata;
                    end
                    if (k == LAST_K) begin
                        state <= S_SEND;
                        k     <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_SEND: begin
                    if (pkt_ready) begin
                        if (r == LAST_R) begin
                            state <= S_DONE;
                        end else begin
                            r     <= r + 1'b1;
                            state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/filter_seq_ctrl.md
Name: filter_seq_ctrl

Overview:
- Clocked sequencer for the 5x5 filter weight store.
- On a load command it streams DEPTH_F*DEPTH_F weights from an input valid/ready stream into an external single-port-per-direction weight memory, in raster order.
- It then reads the memory back row by row and emits one packet per row: {4-bit row index, DEPTH_F bytes}, over a valid/ready output toward the PE array.

Parameters:
WIDTH, 8, weight byte width
DEPTH_F, 5, filter side; DEPTH_F*DEPTH_F words per filter
ADDR_WIDTH, 5, memory address width; must satisfy 2^ADDR_WIDTH >= DEPTH_F*DEPTH_F
PACK_WIDTH, 44, packet width = 4 + DEPTH_F*WIDTH
RD_LAT, 1, cycles from mem_re to valid mem_rdata (1..3)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
load_start  in  1  single-cycle command; start load-then-send sequence
wr_in_valid  in  1  weight stream valid
wr_in_ready  out  1  weight stream ready
wr_in_data  in  WIDTH  weight byte, raster order (row-major, column 0 first)
mem_we  out  1  memory write enable
mem_waddr  out  ADDR_WIDTH  write address
mem_wdata  out  WIDTH  write data
mem_re  out  1  memory read enable
mem_raddr  out  ADDR_WIDTH  read address
mem_rdata  in  WIDTH  read data, valid RD_LAT cycles after mem_re
pkt_valid  out  1  packet valid
pkt_ready  in  1  packet ready
pkt_data  out  PACK_WIDTH  packet {row[3:0], byte[DEPTH_F-1]..byte[0]}
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse after last packet accepted

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; all counters 0; pkt_data 0.
  - All outputs 0.
- State IDLE:
  - wr_in_ready = 0.
  - load_start = 1 -> LOAD next cycle; word counter w = 0.
- State LOAD:
  - wr_in_ready = 1.
  - Each cycle with wr_in_valid & wr_in_ready:
    - mem_we = 1 combinationally in that cycle; mem_waddr = w; mem_wdata = wr_in_data.
    - w increments.
  - Beat at w = DEPTH_F*DEPTH_F-1 -> READ next cycle; row r = 0.
  - No beat -> mem_we = 0; no state change.
- State READ:
  - Issue DEPTH_F consecutive reads, one per cycle: mem_re = 1, mem_raddr = r*DEPTH_F + c, c = 0..DEPTH_F-1.
  - Capture each mem_rdata RD_LAT cycles after its read, into lane c = bits [WIDTH*c+WIDTH-1 : WIDTH*c].
  - After the last lane is captured -> SEND.
  - READ duration: DEPTH_F + RD_LAT cycles.
- State SEND:
  - pkt_valid = 1; pkt_data = {r zero-extended to 4 bits, lanes}.
  - pkt_data is held stable while pkt_valid & !pkt_ready.
  - On pkt_valid & pkt_ready:
    - If r < DEPTH_F-1: r++ and -> READ.
    - Else: -> DONE.
  - pkt_valid is deasserted the cycle after acceptance; there are no back-to-back packets.
- State DONE: done = 1 for one cycle -> IDLE.
- Boundaries:
  - load_start outside IDLE is ignored (not queued).
  - wr_in_valid in IDLE, READ, SEND or DONE: not accepted (ready = 0); data stays pending at the source.
  - mem_we and mem_re are never high in the same cycle.
  - Reset mid-LOAD or mid-SEND aborts immediately. Partial memory contents are left as written; the next sequence requires a fresh load_start.
  - Row index and addresses never wrap past DEPTH_F*DEPTH_F-1.

Optional Feature:
- Macro: FILTER_REPLAY_EN.
- Defined:
  - Adds input replay_start (1 bit).
  - replay_start in IDLE, with a "loaded" flag set, -> READ with r = 0, skipping LOAD.
  - "loaded" flag: set when LOAD completes; cleared by rst and on entry to LOAD.
  - If load_start and replay_start are both high in IDLE, load_start wins.
  - replay_start while loaded = 0 is ignored.
- Undefined: no replay_start port; every sequence starts with LOAD.

Test Plan:
1. Basic sequence.
   - Stimulus: reset, load_start, stream bytes 0x00..0x18 back-to-back, pkt_ready = 1.
   - Required: 25 writes at addr 0..24; 5 packets.
   - Packet 0 = {4'h0, 0x0403020100}; packet 4 = {4'h4, 0x1817161514}.
   - done pulse once; busy low afterwards.
2. Input gaps and output backpressure.
   - Stimulus: wr_in_valid toggled every other cycle; pkt_ready held low 7 cycles on packet 2.
   - Required: 25 writes, no duplicates; pkt_data for packet 2 stable through the stall; total of 5 packets.
3. Ignored commands.
   - Stimulus: load_start pulsed during LOAD and again during SEND.
   - Required: no restart; the single sequence completes normally with one done pulse.
4. Reset mid-operation.
   - Stimulus: rst asserted after 10 writes.
   - Required: all outputs 0 immediately; state IDLE.
   - A following load_start plus 25 bytes produces correct packets.
5. RD_LAT = 3 build.
   - Stimulus: same stimulus as test 1.
   - Required: identical packet contents; each READ phase is 8 cycles.
6. Replay (FILTER_REPLAY_EN).
   - Stimulus: after test 1, pulse replay_start.
   - Required: 5 identical packets with no writes.
   - replay_start before any load: ignored.
   - Simultaneous load_start and replay_start: LOAD is entered.
